// File: rtl/simon_round_seq_if.sv
// Handshake/bus bundle between the Simon round sequencer and its surroundings
// (pattern memory, button debouncer, LED driver, game controller).
interface simon_round_seq_if;
  logic       start_round;
  logic [4:0] round_len;
  logic [4:0] step_addr;
  logic [1:0] pattern_step;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic [3:0] led;
  logic       busy;
  logic       round_pass;
  logic       round_fail;
  logic       fail_timeout;

  modport master (
    output start_round, round_len, pattern_step, btn_valid, btn_code,
    input  step_addr, led, busy, round_pass, round_fail, fail_timeout
  );

  modport slave (
    input  start_round, round_len, pattern_step, btn_valid, btn_code,
    output step_addr, led, busy, round_pass, round_fail, fail_timeout
  );
endinterface

// File: rtl/simon_round_seq.sv
// Simon game round sequencer: plays a stored colour pattern on the LEDs, then
// checks the player's presses against it with a per-press timeout.
module simon_round_seq #(
  parameter logic [23:0] SHOW_CYCLES    = 24'd12_500_000,
  parameter logic [23:0] GAP_CYCLES     = 24'd5_000_000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16_000_000
) (
  input  logic              clock,
  input  logic              reset,
  simon_round_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_WAIT_IN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [23:0] SHOW_LAST    = SHOW_CYCLES - 24'd1;
  localparam logic [23:0] GAP_LAST     = GAP_CYCLES - 24'd1;
  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

  state_t      state, state_nx;
  logic [23:0] cnt, cnt_nx;
  logic [4:0]  idx, idx_nx;
  logic [4:0]  len, len_nx;
  logic        fto, fto_nx;

  logic        last_step;
  logic        press_ok;

  function automatic logic [3:0] colour_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  assign last_step = (idx == (len - 5'd1));
  assign press_ok  = (bus.btn_code == bus.pattern_step);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 24'd0;
      idx   <= 5'd0;
      len   <= 5'd0;
      fto   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      len   <= len_nx;
      fto   <= fto_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    len_nx   = len;
    fto_nx   = fto;
    case (state)
      S_IDLE: begin
        // A zero-length round is a no-op rather than an immediate pass.
        if (bus.start_round && (bus.round_len != 5'd0)) begin
          len_nx   = bus.round_len;
          idx_nx   = 5'd0;
          cnt_nx   = 24'd0;
          fto_nx   = 1'b0;
          state_nx = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nx   = 24'd0;
          state_nx = S_GAP;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = 24'd0;
          if (last_step) begin
            idx_nx   = 5'd0;
            state_nx = S_WAIT_IN;
          end else begin
            idx_nx   = idx + 5'd1;
            state_nx = S_SHOW;
          end
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      S_WAIT_IN: begin
        // A press landing on the final timeout cycle wins over the timeout.
        if (bus.btn_valid) begin
          if (!press_ok) begin
            fto_nx   = 1'b0;
            state_nx = S_FAIL;
          end else if (last_step) begin
            state_nx = S_PASS;
          end else begin
            idx_nx = idx + 5'd1;
            cnt_nx = 24'd0;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          fto_nx   = 1'b1;
          state_nx = S_FAIL;
        end else begin
          cnt_nx = cnt + 24'd1;
        end
      end
      S_PASS:  state_nx = S_IDLE;
      S_FAIL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.step_addr    = idx;
  assign bus.led          = (state == S_SHOW) ? colour_onehot(bus.pattern_step) : 4'b0000;
  assign bus.busy         = (state != S_IDLE);
  assign bus.round_pass   = (state == S_PASS);
  assign bus.round_fail   = (state == S_FAIL);
  assign bus.fail_timeout = (state == S_FAIL) && fto;

endmodule

// File: tb/tb_simon_round_seq.sv
// Self-checking bench for simon_round_seq with short show/gap/timeout periods.
module tb_simon_round_seq;
  localparam logic [23:0] SHOW = 24'd4;
  localparam logic [23:0] GAP  = 24'd2;
  localparam logic [23:0] TO   = 24'd10;
  localparam int          STEP_CYC = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  simon_round_seq_if bus();
  logic [1:0] pat [0:31];

  assign bus.pattern_step = pat[bus.step_addr];

  simon_round_seq #(.SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  logic [2:0] exp_q [$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input logic [4:0] len);
    bus.round_len   = len;
    bus.start_round = 1'b1;
    tick();
    bus.start_round = 1'b0;
  endtask

  task automatic press(input logic [1:0] code);
    bus.btn_code  = code;
    bus.btn_valid = 1'b1;
    tick();
    bus.btn_valid = 1'b0;
  endtask

  task automatic wait_outcome(input int budget, output logic [2:0] obs, output int cyc);
    obs = 3'b000;
    cyc = -1;
    for (int i = 0; i <= budget; i++) begin
      if (bus.round_pass || bus.round_fail) begin
        obs = {bus.round_pass, bus.round_fail, bus.fail_timeout};
        cyc = i;
        return;
      end
      tick();
    end
  endtask

  function automatic logic [3:0] exp_led(input int k);
    int s;
    int p;
    s = k / STEP_CYC;
    p = k % STEP_CYC;
    return (p < int'(SHOW)) ? (4'b0001 << pat[s]) : 4'b0000;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    skip(2);
    checks++; if (bus.led !== 4'b0) $display("FAIL reset_led got %b want 0000", bus.led); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.round_pass !== 1'b0) $display("FAIL reset_pass got %b want 0", bus.round_pass); else passed++;
    checks++; if (bus.round_fail !== 1'b0) $display("FAIL reset_fail got %b want 0", bus.round_fail); else passed++;
    checks++; if (bus.fail_timeout !== 1'b0) $display("FAIL reset_fto got %b want 0", bus.fail_timeout); else passed++;
    checks++; if (bus.step_addr !== 5'd0) $display("FAIL reset_addr got %0d want 0", bus.step_addr); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_show_and_pass();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd2; pat[1] = 2'd0;
    start(5'd2);
    for (int k = 0; k < 2 * STEP_CYC; k++) begin
      checks++; if (bus.led !== exp_led(k)) $display("FAIL show_led k=%0d got %b want %b", k, bus.led, exp_led(k)); else passed++;
      checks++; if (bus.busy !== 1'b1) $display("FAIL show_busy k=%0d got %b want 1", k, bus.busy); else passed++;
      checks++; if (bus.step_addr !== 5'(k / STEP_CYC)) $display("FAIL show_addr k=%0d got %0d want %0d", k, bus.step_addr, k / STEP_CYC); else passed++;
      tick();
    end
    checks++; if (bus.led !== 4'b0) $display("FAIL wait_led got %b want 0000", bus.led); else passed++;
    checks++; if (bus.step_addr !== 5'd0) $display("FAIL wait_addr got %0d want 0", bus.step_addr); else passed++;
    skip(3);
    press(2'd2);
    checks++; if (bus.step_addr !== 5'd1) $display("FAIL press1_addr got %0d want 1", bus.step_addr); else passed++;
    checks++; if (bus.round_pass !== 1'b0) $display("FAIL press1_pass got %b want 0", bus.round_pass); else passed++;
    skip(2);
    exp_q.push_back(3'b100);
    press(2'd0);
    wait_outcome(3, obs, cyc);
    checks++; if (cyc !== 0) $display("FAIL pass_latency got %0d want 0", cyc); else passed++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL pass_outcome got %b want %b", obs, e); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL pass_idle_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.round_pass !== 1'b0) $display("FAIL pass_width got %b want 0", bus.round_pass); else passed++;
  endtask

  task automatic test_wrong_colour();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd2; pat[1] = 2'd0;
    start(5'd2);
    skip(2 * STEP_CYC);
    exp_q.push_back(3'b010);
    press(2'd1);
    wait_outcome(3, obs, cyc);
    checks++; if (cyc !== 0) $display("FAIL wrong_latency got %0d want 0", cyc); else passed++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL wrong_outcome got %b want %b", obs, e); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL wrong_idle_busy got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_timeout();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd2; pat[1] = 2'd0;
    start(5'd2);
    skip(2 * STEP_CYC);
    exp_q.push_back(3'b011);
    wait_outcome(30, obs, cyc);
    checks++; if (cyc !== int'(TO)) $display("FAIL timeout_latency got %0d want %0d", cyc, TO); else passed++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL timeout_outcome got %b want %b", obs, e); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL timeout_idle_busy got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_timeout_edge_press();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd2; pat[1] = 2'd0;
    start(5'd2);
    skip(2 * STEP_CYC);
    skip(int'(TO) - 1);
    press(2'd2);
    checks++; if (bus.round_fail !== 1'b0) $display("FAIL edge_press_fail got %b want 0", bus.round_fail); else passed++;
    checks++; if (bus.step_addr !== 5'd1) $display("FAIL edge_press_addr got %0d want 1", bus.step_addr); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL edge_press_busy got %b want 1", bus.busy); else passed++;
    skip(int'(TO) - 1);
    exp_q.push_back(3'b100);
    press(2'd0);
    wait_outcome(3, obs, cyc);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL edge_press_outcome got %b want %b", obs, e); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_round();
    logic seen;
    pat[0] = 2'd2; pat[1] = 2'd0;
    start(5'd2);
    skip(2);
    checks++; if (bus.led !== 4'b0100) $display("FAIL mid_show_led got %b want 0100", bus.led); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (bus.led !== 4'b0) $display("FAIL rst_show_led got %b want 0000", bus.led); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_show_busy got %b want 0", bus.busy); else passed++;
    #2;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= bus.round_pass | bus.round_fail | bus.busy;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rst_show_quiet got %b want 0", seen); else passed++;

    start(5'd2);
    skip(2 * STEP_CYC + 2);
    checks++; if (bus.busy !== 1'b1) $display("FAIL mid_wait_busy got %b want 1", bus.busy); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rst_wait_busy got %b want 0", bus.busy); else passed++;
    checks++; if (bus.step_addr !== 5'd0) $display("FAIL rst_wait_addr got %0d want 0", bus.step_addr); else passed++;
    #2;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= bus.round_pass | bus.round_fail | bus.busy;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rst_wait_quiet got %b want 0", seen); else passed++;
  endtask

  task automatic test_zero_len();
    logic seen;
    bus.round_len   = 5'd0;
    bus.start_round = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= bus.busy | bus.round_pass | bus.round_fail;
    end
    bus.start_round = 1'b0;
    checks++; if (seen !== 1'b0) $display("FAIL zero_len_quiet got %b want 0", seen); else passed++;
  endtask

  task automatic test_ignored_inputs();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd1; pat[1] = 2'd3;
    start(5'd2);
    for (int k = 0; k < 2 * STEP_CYC; k++) begin
      bus.btn_valid   = 1'b1;
      bus.btn_code    = 2'd0;
      bus.start_round = (k % 3 == 0);
      bus.round_len   = 5'd7;
      checks++; if (bus.led !== exp_led(k)) $display("FAIL ign_led k=%0d got %b want %b", k, bus.led, exp_led(k)); else passed++;
      checks++; if (bus.step_addr !== 5'(k / STEP_CYC)) $display("FAIL ign_addr k=%0d got %0d want %0d", k, bus.step_addr, k / STEP_CYC); else passed++;
      tick();
    end
    bus.btn_valid   = 1'b0;
    bus.start_round = 1'b0;
    checks++; if (bus.round_fail !== 1'b0) $display("FAIL ign_no_fail got %b want 0", bus.round_fail); else passed++;
    press(2'd1);
    exp_q.push_back(3'b100);
    press(2'd3);
    wait_outcome(3, obs, cyc);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL ign_outcome got %b want %b", obs, e); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs;
    logic [2:0] e;
    int cyc;
    pat[0] = 2'd3;
    bus.round_len   = 5'd1;
    bus.start_round = 1'b1;
    tick();
    skip(STEP_CYC);
    exp_q.push_back(3'b100);
    press(2'd3);
    wait_outcome(2, obs, cyc);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    checks++; if (obs !== e) $display("FAIL b2b_outcome got %b want %b", obs, e); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", bus.busy); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_restart_busy got %b want 1", bus.busy); else passed++;
    checks++; if (bus.led !== 4'b1000) $display("FAIL b2b_restart_led got %b want 1000", bus.led); else passed++;
    bus.start_round = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    bus.start_round = 1'b0;
    bus.round_len   = 5'd0;
    bus.btn_valid   = 1'b0;
    bus.btn_code    = 2'd0;
    for (int i = 0; i < 32; i++) pat[i] = 2'd0;
    test_reset();
    test_show_and_pass();
    test_wrong_colour();
    test_timeout();
    test_timeout_edge_press();
    test_reset_mid_round();
    test_zero_len();
    test_ignored_inputs();
    test_back_to_back();
    checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/simon_round_seq.md
SIMON_ROUND_SEQ -- requirements
Module: simon_round_seq

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 24'd12_500_000: clock cycles each pattern LED is lit (range 1..2^24-1).
REQ-002 SHALL have parameter GAP_CYCLES, default 24'd5_000_000: dark cycles after each shown LED (range 1..2^24-1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd16_000_000: maximum cycles allowed per player press (range 1..2^24-1).
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start_round  in  1  level; sampled only in IDLE.
REQ-007 round_len  in  5  number of steps in the round (1..31); sampled when the round starts.
REQ-008 step_addr  out  5  pattern memory address, equal to the current step index.
REQ-009 pattern_step  in  2  colour code (0..3) at step_addr, combinational read, valid in the same cycle.
REQ-010 btn_valid  in  1  one-cycle pulse, debounced player press.
REQ-011 btn_code  in  2  colour of the press, valid with btn_valid.
REQ-012 led  out  4  one-hot colour display; 4'b0000 = dark.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 round_pass  out  1  one-cycle pulse: all steps entered correctly.
REQ-015 round_fail  out  1  one-cycle pulse: wrong press or timeout.
REQ-016 fail_timeout  out  1  valid with round_fail: 1 = timeout, 0 = wrong colour.

Function
REQ-017 States SHALL be IDLE, SHOW, GAP, WAIT_IN, PASS and FAIL. One shared 24-bit cycle counter cnt and a 5-bit step index idx SHALL be used. Outputs SHALL be decoded from the registered state only.
REQ-018 IDLE + start_round=1 + round_len!=0 SHALL capture len=round_len, clear idx and cnt, and enter SHOW the next cycle. If round_len==0, the block SHALL stay in IDLE with no pulse.
REQ-019 start_round SHALL be ignored outside IDLE. A level held high SHALL restart a new round the cycle after PASS or FAIL returns to IDLE.
REQ-020 SHOW: led=1<<pattern_step and cnt increments each cycle. At cnt==SHOW_CYCLES-1 the block SHALL enter GAP with cnt=0, so the LED is lit exactly SHOW_CYCLES cycles.
REQ-021 GAP: led=0 for exactly GAP_CYCLES cycles, then:
- if idx==len-1: enter WAIT_IN with idx=0, cnt=0;
- else: idx+1, enter SHOW with cnt=0.
REQ-022 WAIT_IN: led=0 and cnt increments. On btn_valid:
- btn_code==pattern_step and idx==len-1: enter PASS;
- btn_code==pattern_step otherwise: idx+1, cnt=0 (timeout restarts per press);
- btn_code!=pattern_step: enter FAIL with fail_timeout=0.
REQ-023 WAIT_IN with cnt==TIMEOUT_CYCLES-1 and no btn_valid SHALL enter FAIL with fail_timeout=1. If btn_valid coincides with the timeout cycle, the press SHALL take priority.
REQ-024 btn_valid SHALL be ignored in IDLE, SHOW, GAP, PASS and FAIL.
REQ-025 PASS SHALL assert round_pass for one cycle, then go to IDLE. FAIL SHALL assert round_fail (with fail_timeout held) for one cycle, then go to IDLE.
REQ-026 step_addr SHALL equal idx in all states. idx SHALL never exceed len-1.
REQ-027 cnt SHALL never wrap: every terminal compare above occurs before 2^24-1.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, force:
- state=IDLE; idx=0; cnt=0; len=0;
- led=0, busy=0, round_pass=0, round_fail=0, fail_timeout=0.
REQ-029 Reset asserted mid-round (any state) SHALL abandon the round with no pass/fail pulse. After reset deasserts, the first action SHALL be a new start_round.

Verification (SHOW=4, GAP=2, TIMEOUT=10)
REQ-030 Stimulus: round_len=2, pattern {2,0}.
Response: led=4'b0100 for 4 cycles, 0 for 2, 4'b0001 for 4, 0 for 2. busy high from the cycle after start.
REQ-031 Stimulus: same round, presses 2 then 0, each within 10 cycles.
Response: round_pass pulses one cycle after the second press's edge, then busy=0.
REQ-032 Stimulus: press 1 where pattern_step=2.
Response: round_fail=1, fail_timeout=0 for one cycle, then IDLE.
REQ-033 Stimulus: no press in WAIT_IN.
Response: round_fail with fail_timeout=1 exactly 10 cycles after WAIT_IN entry. A correct press on the 10th cycle SHALL instead advance idx.
REQ-034 Stimulus: reset pulse during SHOW, and a separate reset pulse during WAIT_IN.
Response: led/busy drop to 0 asynchronously, no pulses. round_len=0 with start_round leaves busy=0.
REQ-035 Stimulus: btn_valid during SHOW/GAP, and start_round pulsed during a round.
Response: both have no effect on led timing, idx or outcome.
